ascon_dec_seq: RTL and testbench

Iterative ASCON-128 decryption sequencer. It replaces the fully unrolled combinational decrypt path with one shared permutation round, a 320-bit state register and an FSM that schedules every phase: init, key mix, two ciphertext blocks, padding, finalization and tag. It decrypts one 128-bit ciphertext with an empty associated-data string. It sits between the host register interface and the crypto datapath.

---
 rtl/ascon_dec_seq_if.sv | 26 ++
 rtl/ascon_dec_seq.sv | 209 ++++++++++++++++++++
 tb/tb_ascon_dec_seq.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_dec_seq_if.sv
// ascon_dec_seq_if: host-side bundle for the iterative ASCON-128 decrypt sequencer (ASCON_TAG_CHECK_EN adds tag check signals)
interface ascon_dec_seq_if;
  logic        start;
  logic [63:0] iv, k0, k1, n0, n1, cyp0, cyp1;
  logic [63:0] pln0, pln1, tag0, tag1;
  logic [63:0] y0, y1, y2, y3, y4;
  logic        busy, done;
`ifdef ASCON_TAG_CHECK_EN
  logic [63:0] tag_in0, tag_in1;
  logic        tag_ok;
`endif
  modport master (
`ifdef ASCON_TAG_CHECK_EN
    output tag_in0, tag_in1, input tag_ok,
`endif
    output start, iv, k0, k1, n0, n1, cyp0, cyp1,
    input  pln0, pln1, tag0, tag1, y0, y1, y2, y3, y4, busy, done
  );
  modport slave (
`ifdef ASCON_TAG_CHECK_EN
    input tag_in0, tag_in1, output tag_ok,
`endif
    input  start, iv, k0, k1, n0, n1, cyp0, cyp1,
    output pln0, pln1, tag0, tag1, y0, y1, y2, y3, y4, busy, done
  );
endinterface

// File: rtl/ascon_dec_seq.sv
// ascon_dec_seq: iterative ASCON-128 decrypt (one round per cycle, empty AD); ASCON_TAG_CHECK_EN enables tag verification
module ascon_dec_seq #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input logic clk,
  input logic rst,
  ascon_dec_seq_if.slave bus
);
  typedef enum logic [3:0] {IDLE, INIT, KEYX, ABS0, PB0, ABS1, PB1, FIN, PA, TAG} state_t;
  localparam logic [3:0]  RA0 = 4'(12 - ROUNDS_A);
  localparam logic [3:0]  RB0 = 4'(12 - ROUNDS_B);
  localparam logic [63:0] PAD = 64'h8000000000000000;
  state_t            state_q, state_d;
  logic [3:0]        rnd_q, rnd_d;
  logic [4:0][63:0]  s_q, s_d, s_rnd;
  logic [63:0]       k0_q, k0_d, k1_q, k1_d, c0_q, c0_d, c1_q, c1_d;
  logic [63:0]       pln0_q, pln0_d, pln1_q, pln1_d, tag0_q, tag0_d, tag1_q, tag1_d;
  logic              busy_q, busy_d, done_q, done_d, last;
`ifdef ASCON_TAG_CHECK_EN
  logic [63:0]       ti0_q, ti0_d, ti1_q, ti1_d;
  logic              tag_ok_q, tag_ok_d;
`endif
  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  function automatic logic [4:0][63:0] ascon_round(input logic [4:0][63:0] s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[0];
    x1 = s[1];
    x2 = s[2] ^ {56'd0, ~r, r};
    x3 = s[3];
    x4 = s[4];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    return {x4 ^ ror(x4, 7) ^ ror(x4, 41),
            x3 ^ ror(x3, 10) ^ ror(x3, 17),
            x2 ^ ror(x2, 1) ^ ror(x2, 6),
            x1 ^ ror(x1, 61) ^ ror(x1, 39),
            x0 ^ ror(x0, 19) ^ ror(x0, 28)};
  endfunction
  assign s_rnd = ascon_round(s_q, rnd_q);
  assign last  = rnd_q == 4'd11;
  // next-state and datapath schedule for every phase of the decrypt
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    s_d     = s_q;
    k0_d    = k0_q;
    k1_d    = k1_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    pln0_d  = pln0_q;
    pln1_d  = pln1_q;
    tag0_d  = tag0_q;
    tag1_d  = tag1_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef ASCON_TAG_CHECK_EN
    ti0_d    = ti0_q;
    ti1_d    = ti1_q;
    tag_ok_d = tag_ok_q;
`endif
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = INIT;
        rnd_d   = RA0;
        busy_d  = 1'b1;
        s_d     = {bus.n1, bus.n0, bus.k1, bus.k0, bus.iv};
        k0_d    = bus.k0;
        k1_d    = bus.k1;
        c0_d    = bus.cyp0;
        c1_d    = bus.cyp1;
`ifdef ASCON_TAG_CHECK_EN
        ti0_d   = bus.tag_in0;
        ti1_d   = bus.tag_in1;
`endif
      end
      INIT: begin
        s_d     = s_rnd;
        rnd_d   = rnd_q + 4'd1;
        state_d = last ? KEYX : INIT;
      end
      KEYX: begin
        s_d[3]  = s_q[3] ^ k0_q;
        s_d[4]  = s_q[4] ^ k1_q ^ 64'd1;
        state_d = ABS0;
      end
      ABS0: begin
        pln0_d  = c0_q ^ s_q[0];
        s_d[0]  = c0_q;
        rnd_d   = RB0;
        state_d = PB0;
      end
      PB0: begin
        s_d     = s_rnd;
        rnd_d   = rnd_q + 4'd1;
        state_d = last ? ABS1 : PB0;
      end
      ABS1: begin
        pln1_d  = c1_q ^ s_q[0];
        s_d[0]  = c1_q;
        rnd_d   = RB0;
        state_d = PB1;
      end
      PB1: begin
        s_d     = s_rnd;
        rnd_d   = rnd_q + 4'd1;
        state_d = last ? FIN : PB1;
      end
      FIN: begin
        s_d[0]  = s_q[0] ^ PAD;
        s_d[1]  = s_q[1] ^ k0_q;
        s_d[2]  = s_q[2] ^ k1_q;
        rnd_d   = RA0;
        state_d = PA;
      end
      PA: begin
        s_d     = s_rnd;
        rnd_d   = rnd_q + 4'd1;
        state_d = last ? TAG : PA;
      end
      TAG: begin
        tag0_d  = s_q[3] ^ k0_q;
        tag1_d  = s_q[4] ^ k1_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef ASCON_TAG_CHECK_EN
        tag_ok_d = {tag0_d, tag1_d} == {ti0_q, ti1_q};
        pln0_d   = tag_ok_d ? pln0_q : '0;
        pln1_d   = tag_ok_d ? pln1_q : '0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  // all state, shadow and output registers; reset aborts any job in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rnd_q    <= '0;
      s_q      <= '0;
      k0_q     <= '0;
      k1_q     <= '0;
      c0_q     <= '0;
      c1_q     <= '0;
      pln0_q   <= '0;
      pln1_q   <= '0;
      tag0_q   <= '0;
      tag1_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ASCON_TAG_CHECK_EN
      ti0_q    <= '0;
      ti1_q    <= '0;
      tag_ok_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      s_q      <= s_d;
      k0_q     <= k0_d;
      k1_q     <= k1_d;
      c0_q     <= c0_d;
      c1_q     <= c1_d;
      pln0_q   <= pln0_d;
      pln1_q   <= pln1_d;
      tag0_q   <= tag0_d;
      tag1_q   <= tag1_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef ASCON_TAG_CHECK_EN
      ti0_q    <= ti0_d;
      ti1_q    <= ti1_d;
      tag_ok_q <= tag_ok_d;
`endif
    end
  end
  assign bus.pln0 = pln0_q;
  assign bus.pln1 = pln1_q;
  assign bus.tag0 = tag0_q;
  assign bus.tag1 = tag1_q;
  assign bus.y0   = s_q[0];
  assign bus.y1   = s_q[1];
  assign bus.y2   = s_q[2];
  assign bus.y3   = s_q[3];
  assign bus.y4   = s_q[4];
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef ASCON_TAG_CHECK_EN
  assign bus.tag_ok = tag_ok_q;
`endif
endmodule

// File: tb/tb_ascon_dec_seq.sv
// tb_ascon_dec_seq: randomized checks of ascon_dec_seq against a table-driven ASCON-128 reference model
module tb_ascon_dec_seq;
  localparam int RA = 12;
  localparam int RB = 6;
  localparam int LAT = 2 * RA + 2 * RB + 5;
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int ROT1 [5] = '{19, 61, 1, 10, 7};
  localparam int ROT2 [5] = '{28, 39, 6, 17, 41};
  typedef struct {
    logic [63:0] iv, k0, k1, n0, n1, c0, c1, t0, t1;
  } job_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  logic [4:0][63:0] tr [0:LAT];
  logic [63:0] e_p0, e_p1, e_t0, e_t1;
  logic e_ok;
  job_t kat;
  ascon_dec_seq_if bus ();
  ascon_dec_seq #(.ROUNDS_A(RA), .ROUNDS_B(RB)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic logic [63:0] rotr(input logic [63:0] x, input int a);
    return (x >> a) | (x << (64 - a));
  endfunction
  function automatic logic [4:0][63:0] model_round(input logic [4:0][63:0] si, input int r);
    logic [4:0][63:0] s, n;
    logic [4:0] o;
    s = si;
    s[2] = s[2] ^ 64'((15 - r) * 16 + r);
    for (int i = 0; i < 64; i++) begin
      o = SBOX[{s[0][i], s[1][i], s[2][i], s[3][i], s[4][i]}];
      for (int w = 0; w < 5; w++) n[w][i] = o[4 - w];
    end
    for (int w = 0; w < 5; w++) n[w] = n[w] ^ rotr(n[w], ROT1[w]) ^ rotr(n[w], ROT2[w]);
    return n;
  endfunction
  function automatic logic [4:0][63:0] y_now();
    return {bus.y4, bus.y3, bus.y2, bus.y1, bus.y0};
  endfunction
  function automatic logic [255:0] res_now();
    return {bus.pln0, bus.pln1, bus.tag0, bus.tag1};
  endfunction
  function automatic logic [255:0] res_exp();
    return {e_p0, e_p1, e_t0, e_t1};
  endfunction
  function automatic logic [575:0] outs_now();
    return {res_now(), y_now()};
  endfunction
  function automatic job_t rand_job();
    job_t j;
    j.iv = {$urandom, $urandom};
    j.k0 = {$urandom, $urandom};
    j.k1 = {$urandom, $urandom};
    j.n0 = {$urandom, $urandom};
    j.n1 = {$urandom, $urandom};
    j.c0 = {$urandom, $urandom};
    j.c1 = {$urandom, $urandom};
    j.t0 = '0;
    j.t1 = '0;
    return j;
  endfunction
  task automatic run_model(input job_t j);
    logic [4:0][63:0] s;
    int k;
    s[0] = j.iv;
    s[1] = j.k0;
    s[2] = j.k1;
    s[3] = j.n0;
    s[4] = j.n1;
    k = 0;
    tr[k] = s;
    for (int r = 12 - RA; r < 12; r++) begin s = model_round(s, r); k++; tr[k] = s; end
    s[3] = s[3] ^ j.k0;
    s[4] = s[4] ^ j.k1 ^ 64'd1;
    k++; tr[k] = s;
    e_p0 = j.c0 ^ s[0];
    s[0] = j.c0;
    k++; tr[k] = s;
    for (int r = 12 - RB; r < 12; r++) begin s = model_round(s, r); k++; tr[k] = s; end
    e_p1 = j.c1 ^ s[0];
    s[0] = j.c1;
    k++; tr[k] = s;
    for (int r = 12 - RB; r < 12; r++) begin s = model_round(s, r); k++; tr[k] = s; end
    s[0] = s[0] ^ 64'h8000000000000000;
    s[1] = s[1] ^ j.k0;
    s[2] = s[2] ^ j.k1;
    k++; tr[k] = s;
    for (int r = 12 - RA; r < 12; r++) begin s = model_round(s, r); k++; tr[k] = s; end
    e_t0 = s[3] ^ j.k0;
    e_t1 = s[4] ^ j.k1;
    k++; tr[k] = s;
    e_ok = (e_t0 == j.t0) && (e_t1 == j.t1);
`ifdef ASCON_TAG_CHECK_EN
    if (!e_ok) begin e_p0 = '0; e_p1 = '0; end
`endif
  endtask
  task automatic fix_tag(inout job_t j);
    run_model(j);
    j.t0 = e_t0;
    j.t1 = e_t1;
    run_model(j);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input job_t j);
    bus.iv = j.iv;
    bus.k0 = j.k0;
    bus.k1 = j.k1;
    bus.n0 = j.n0;
    bus.n1 = j.n1;
    bus.cyp0 = j.c0;
    bus.cyp1 = j.c1;
`ifdef ASCON_TAG_CHECK_EN
    bus.tag_in0 = j.t0;
    bus.tag_in1 = j.t1;
`endif
  endtask
  task automatic launch(input job_t j);
    run_model(j);
    drive(j);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (3) step();
    n_chk++;
    if (outs_now() !== '0) $display("FAIL reset_outs got %h want 0", outs_now()); else n_pass++;
    n_chk++;
    if ({bus.busy, bus.done} !== 2'b00) $display("FAIL reset_flags got %b want 00", {bus.busy, bus.done}); else n_pass++;
`ifdef ASCON_TAG_CHECK_EN
    n_chk++;
    if (bus.tag_ok !== 1'b0) $display("FAIL reset_tag_ok got %b want 0", bus.tag_ok); else n_pass++;
`endif
    bus.start = 1'b1;
    step();
    n_chk++;
    if (bus.busy !== 1'b0) $display("FAIL reset_start_ignored busy got %b want 0", bus.busy); else n_pass++;
    bus.start = 1'b0;
    rst = 1'b0;
    step();
  endtask
  task automatic test_kat();
    launch(kat);
    n_chk++;
    if (y_now() !== tr[0] || bus.busy !== 1'b1) $display("FAIL kat_accept y %h busy %b want %h 1", y_now(), bus.busy, tr[0]); else n_pass++;
    for (int k = 1; k <= LAT; k++) begin
      step();
      n_chk++;
      if (y_now() !== tr[k]) $display("FAIL kat_state E%0d got %h want %h", k, y_now(), tr[k]); else n_pass++;
      n_chk++;
      if ({bus.busy, bus.done} !== {k < LAT, k == LAT}) $display("FAIL kat_flags E%0d got %b want %b", k, {bus.busy, bus.done}, {k < LAT, k == LAT}); else n_pass++;
    end
    n_chk++;
    if (res_now() !== res_exp()) $display("FAIL kat_result got %h want %h", res_now(), res_exp()); else n_pass++;
    repeat (3) step();
    n_chk++;
    if (res_now() !== res_exp() || bus.done !== 1'b0) $display("FAIL kat_hold got %h done %b want %h 0", res_now(), bus.done, res_exp()); else n_pass++;
  endtask
  task automatic test_round_constants();
    job_t j;
    j = rand_job();
    fix_tag(j);
    launch(j);
    for (int k = 1; k <= LAT; k++) begin
      step();
      if (k == 1 || k == RA || k == RA + 3) begin
        n_chk++;
        if (y_now() !== tr[k]) $display("FAIL rc_state E%0d got %h want %h", k, y_now(), tr[k]); else n_pass++;
      end
    end
    n_chk++;
    if (bus.done !== 1'b1 || res_now() !== res_exp()) $display("FAIL rc_result done %b got %h want %h", bus.done, res_now(), res_exp()); else n_pass++;
  endtask
  task automatic test_start_busy();
    job_t ja, jb;
    int n_done;
    ja = rand_job();
    fix_tag(ja);
    jb = rand_job();
    fix_tag(jb);
    launch(ja);
    n_done = 0;
    for (int k = 1; k <= LAT + 4; k++) begin
      if (k == 10) begin drive(jb); bus.start = 1'b1; end
      if (k == 11) bus.start = 1'b0;
      step();
      if (bus.done) n_done++;
      if (k == 10) begin
        n_chk++;
        if (y_now() !== tr[10] || bus.busy !== 1'b1) $display("FAIL busy_start_state got %h busy %b want %h 1", y_now(), bus.busy, tr[10]); else n_pass++;
      end
      if (k == LAT) begin
        n_chk++;
        if (bus.done !== 1'b1 || res_now() !== res_exp()) $display("FAIL busy_start_result done %b got %h want %h", bus.done, res_now(), res_exp()); else n_pass++;
      end
    end
    n_chk++;
    if (n_done !== 1) $display("FAIL busy_start_done_count got %0d want 1", n_done); else n_pass++;
  endtask
  task automatic test_reset_mid();
    launch(kat);
    repeat (20) step();
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if (outs_now() !== '0 || {bus.busy, bus.done} !== 2'b00) $display("FAIL midreset_outs got %h flags %b want 0", outs_now(), {bus.busy, bus.done}); else n_pass++;
    repeat (2) step();
    n_chk++;
    if (bus.done !== 1'b0) $display("FAIL midreset_no_done got %b want 0", bus.done); else n_pass++;
    rst = 1'b0;
    step();
    launch(kat);
    repeat (LAT) step();
    n_chk++;
    if (bus.done !== 1'b1 || res_now() !== res_exp()) $display("FAIL midreset_rerun done %b got %h want %h", bus.done, res_now(), res_exp()); else n_pass++;
  endtask
  task automatic test_back_to_back();
    job_t ja, jb;
    logic [255:0] exp_a, exp_b;
    ja = rand_job();
    fix_tag(ja);
    jb = rand_job();
    fix_tag(jb);
    exp_b = res_exp();
    run_model(ja);
    exp_a = res_exp();
    drive(ja);
    bus.start = 1'b1;
    step();
    drive(jb);
    for (int k = 1; k <= LAT; k++) step();
    n_chk++;
    if (bus.done !== 1'b1 || res_now() !== exp_a) $display("FAIL b2b_first done %b got %h want %h", bus.done, res_now(), exp_a); else n_pass++;
    step();
    bus.start = 1'b0;
    n_chk++;
    if ({bus.busy, bus.done} !== 2'b10 || res_now() !== exp_a) $display("FAIL b2b_accept flags %b got %h want 10 %h", {bus.busy, bus.done}, res_now(), exp_a); else n_pass++;
    for (int k = 1; k <= LAT; k++) begin
      step();
      if (k == LAT - 1) begin
        n_chk++;
        if (bus.done !== 1'b0) $display("FAIL b2b_early_done got %b want 0", bus.done); else n_pass++;
      end
    end
    n_chk++;
    if (bus.done !== 1'b1 || res_now() !== exp_b) $display("FAIL b2b_second done %b got %h want %h", bus.done, res_now(), exp_b); else n_pass++;
  endtask
`ifdef ASCON_TAG_CHECK_EN
  task automatic test_tag_check();
    job_t j;
    j = rand_job();
    fix_tag(j);
    launch(j);
    repeat (LAT) step();
    n_chk++;
    if (bus.tag_ok !== 1'b1 || res_now() !== res_exp()) $display("FAIL tag_good ok %b got %h want 1 %h", bus.tag_ok, res_now(), res_exp()); else n_pass++;
    j.t1[0] = ~j.t1[0];
    launch(j);
    repeat (LAT) step();
    n_chk++;
    if (bus.tag_ok !== 1'b0 || {bus.pln0, bus.pln1} !== 128'd0) $display("FAIL tag_bad ok %b pln %h want 0 0", bus.tag_ok, {bus.pln0, bus.pln1}); else n_pass++;
    n_chk++;
    if ({bus.tag0, bus.tag1} !== {e_t0, e_t1}) $display("FAIL tag_bad_tag got %h want %h", {bus.tag0, bus.tag1}, {e_t0, e_t1}); else n_pass++;
  endtask
`endif
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    kat.iv = 64'h80400C0600000000;
    kat.k0 = 64'h265F1C12888E151A;
    kat.k1 = 64'hC74F26B30A8C44B2;
    kat.n0 = 64'h369C801F3AE8D0EA;
    kat.n1 = 64'h9BF367D58FD211FF;
    kat.c0 = '0;
    kat.c1 = '0;
    kat.t0 = '0;
    kat.t1 = '0;
    fix_tag(kat);
    bus.start = 1'b0;
    drive(kat);
    test_reset();
    test_kat();
    test_round_constants();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
`ifdef ASCON_TAG_CHECK_EN
    test_tag_check();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
